// File: rtl/tt_um_johnson_decoder.sv
// Johnson-code receiver tile: decodes an 8-bit twisted-ring code to a step
// index, tracks sequence lock and counts sequence errors.
module tt_um_johnson_decoder #(
  parameter int unsigned LOCK_N     = 3,
  parameter bit          ALLOW_HOLD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_e;

  localparam logic [2:0] LOCK_TGT = 3'(LOCK_N);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic [3:0] exp_q, exp_d;
  logic [2:0] mcnt_q, mcnt_d;
  logic       seq_err_q, seq_err_d;
  logic [3:0] err_cnt_q, err_cnt_d;

  logic       sample;
  logic       err_inc;
  logic       is_hold;
  logic [3:0] pop;
  logic [7:0] lo_mask;
  logic [7:0] hi_mask;
  logic [3:0] dec_idx;
  logic       dec_valid;
  logic       unused_bits;

  assign sample      = ena & uio_in[0];
  assign unused_bits = ^uio_in[7:2];

  // Decode the raw code: ones must be contiguous from LSB (rising half) or from MSB (falling half)
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      pop = pop + {3'b000, ui_in[i]};
    end
    lo_mask   = 8'((9'd1 << pop) - 9'd1);
    hi_mask   = ~8'((9'd1 << (4'd8 - pop)) - 9'd1);
    dec_valid = 1'b0;
    dec_idx   = '0;
    if (ui_in == 8'hFF) begin
      dec_valid = 1'b1;
      dec_idx   = 4'd8;
    end else if (!ui_in[7]) begin
      dec_valid = (ui_in == lo_mask);
      dec_idx   = dec_valid ? pop : 4'd0;
    end else begin
      dec_valid = (ui_in == hi_mask);
      dec_idx   = dec_valid ? 4'(5'd16 - {1'b0, pop}) : 4'd0;
    end
  end

  assign is_hold = ALLOW_HOLD && (dec_idx == exp_q - 4'd1);

  // Next-state logic: sequence tracking, lock FSM and error counter
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    exp_d     = exp_q;
    mcnt_d    = mcnt_q;
    seq_err_d = 1'b0;
    err_inc   = 1'b0;
    err_cnt_d = err_cnt_q;
    if (sample) begin
      idx_d   = dec_idx;
      valid_d = dec_valid;
      case (state_q)
        HUNT: begin
          if (dec_valid) begin
            exp_d   = dec_idx + 4'd1;
            mcnt_d  = 3'd1;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (!dec_valid) begin
            state_d = HUNT;
            mcnt_d  = '0;
          end else if (dec_idx == exp_q) begin
            exp_d  = dec_idx + 4'd1;
            mcnt_d = mcnt_q + 3'd1;
            if (mcnt_q + 3'd1 == LOCK_TGT) state_d = LOCKED;
          end else if (is_hold) begin
            state_d = CHECK;
          end else begin
            exp_d  = dec_idx + 4'd1;
            mcnt_d = 3'd1;
          end
        end
        LOCKED: begin
          if (dec_valid && dec_idx == exp_q) begin
            exp_d = dec_idx + 4'd1;
          end else if (dec_valid && is_hold) begin
            state_d = LOCKED;
          end else begin
            seq_err_d = 1'b1;
            err_inc   = 1'b1;
            state_d   = HUNT;
            mcnt_d    = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    // Clear takes priority over a same-cycle increment; the pulse itself is unaffected
    if (ena && uio_in[1]) begin
      err_cnt_d = '0;
    end else if (err_inc && err_cnt_q != 4'hF) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      exp_q     <= '0;
      mcnt_q    <= '0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      exp_q     <= exp_d;
      mcnt_q    <= mcnt_d;
      seq_err_q <= seq_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign uo_out  = {state_q == CHECK, seq_err_q, state_q == LOCKED, valid_q, idx_q};
  assign uio_out = {err_cnt_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule
